// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding an 8N1 UART serialiser.
// The baud divisor is captured at each frame start so a divisor change never distorts a frame in flight.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             tx,
    output logic             busy,
    output logic [4:0]       fifo_count
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [4:0]       count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic push_s;
    logic pop_s;
    logic bit_end_s;

    assign wr_ready   = (count_q < DEPTH_C);
    assign push_s     = wr_valid & wr_ready;
    assign bit_end_s  = (baud_q == div_q);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Serialiser next-state: a pop loads the shifter and starts a frame straight from IDLE or STOP.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 5'd0) begin
                    pop_s   = 1'b1;
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = clk_div;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (!bit_end_s) begin
                    baud_d = baud_q + DIV_W'(1);
                end else if (count_q != 5'd0) begin
                    pop_s   = 1'b1;
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = clk_div;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping: the occupancy count alone decides full and empty.
    always_comb begin
        count_d  = count_q + 5'(push_s) - 5'(pop_s);
        wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    // State and output registers; reset drops any frame in flight and empties the FIFO.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array needs no reset since the pointers and count define its valid contents.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes every frame against a byte scoreboard.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clk_div = 16'd3;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    int         cur_div = 3;
    int         fdiv = 0;
    bit         in_frame = 1'b0;
    int         mon_k = 0;
    logic [7:0] cur_byte = 8'd0;
    int         frames_done = 0;
    int         cyc = 0;
    int         last_end = -100;
    int         last_gap = -1;

    uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .clk_div   (clk_div),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial forever #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx == 9) return 1'b1;
        else return b[idx-1];
    endfunction

    // Line monitor: checks every cycle of every frame against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
                sb.delete();
            end else begin
                if (!in_frame) begin
                    if (tx === 1'b0) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame at cycle %0d: got a start bit, required idle line", cyc);
                            cur_byte = 8'hFF;
                        end else begin
                            cur_byte = sb.pop_front();
                        end
                        in_frame = 1'b1;
                        mon_k    = 0;
                        fdiv     = cur_div;
                        last_gap = cyc - last_end - 1;
                    end else begin
                        checks++;
                        if (busy !== 1'b0) begin
                            errors++;
                            $display("FAIL idle_busy at cycle %0d: got busy=%b, required 0", cyc, busy);
                        end
                    end
                end
                if (in_frame) begin
                    checks++;
                    if (tx !== frame_bit(cur_byte, mon_k / (fdiv + 1)) || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_bit byte=%02h bit=%0d cyc_in_frame=%0d: got tx=%b busy=%b, required tx=%b busy=1",
                                 cur_byte, mon_k / (fdiv + 1), mon_k, tx, busy, frame_bit(cur_byte, mon_k / (fdiv + 1)));
                    end
                    mon_k++;
                    if (mon_k == 10 * (fdiv + 1)) begin
                        in_frame = 1'b0;
                        frames_done++;
                        last_end = cyc;
                    end
                end
            end
        end
    end

    task automatic set_div(input int d);
        clk_div = 16'(d);
        cur_div = d;
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        sb.push_back(b);
        @(posedge clk);
    endtask

    task automatic stop_wr();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int target;
        int t;
        target = frames_done + n;
        t = 0;
        while (frames_done < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d frames, required %0d", name, frames_done, target);
        end
    endtask

    task automatic wait_bit(input int k, input int budget, input string name);
        int t;
        t = 0;
        while (!(in_frame && mon_k == k) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (!(in_frame && mon_k == k)) begin
            errors++;
            $display("FAIL %s_timeout: frame position %0d never reached", name, k);
        end
    endtask

    task automatic test_reset();
        set_div(1);
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1", tx, busy, fifo_count, wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'h3C;
        sb.push_back(8'h3C);
        @(posedge clk);
        stop_wr();
        wait_frames(1, 100, "first_write_after_reset");
    endtask

    task automatic test_single();
        set_div(3);
        put(8'hA5);
        stop_wr();
        wait_frames(1, 100, "single");
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL single_end: got tx=%b busy=%b count=%0d, required 1 0 0", tx, busy, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        set_div(3);
        put(8'hAB);
        put(8'h40);
        stop_wr();
        wait_frames(2, 200, "back_to_back");
        checks++;
        if (last_gap !== 0) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d idle cycles, required 0", last_gap);
        end
    endtask

    task automatic test_full();
        int done0;
        set_div(15);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            checks++;
            if (wr_ready !== (i < 9)) begin
                errors++;
                $display("FAIL full_ready[%0d]: got %b, required %b", i, wr_ready, (i < 9));
            end
            if (i < 9) sb.push_back(8'(i));
            @(posedge clk);
        end
        stop_wr();
        checks++;
        if (fifo_count !== 5'd8 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count: got count=%0d ready=%b, required 8 0", fifo_count, wr_ready);
        end
        wait_frames(9, 9 * 160 + 50, "full_drain");
        done0 = frames_done;
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (frames_done !== done0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL full_extra: got %0d extra frames, %0d unsent, required 0 0", frames_done - done0, sb.size());
        end
    endtask

    task automatic test_div0();
        int busy_n;
        int low_n;
        busy_n = 0;
        low_n  = 0;
        set_div(0);
        put(8'h00);
        stop_wr();
        repeat (30) begin
            @(negedge clk);
            #1;
            if (busy === 1'b1) busy_n++;
            if (tx === 1'b0) low_n++;
        end
        checks++;
        if (busy_n !== 10 || low_n !== 9) begin
            errors++;
            $display("FAIL div0_lengths: got busy=%0d low=%0d cycles, required 10 9", busy_n, low_n);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        set_div(3);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        put(8'h44);
        stop_wr();
        wait_bit(21, 200, "reset_mid");
        checks++;
        if (fifo_count !== 5'd3) begin
            errors++;
            $display("FAIL reset_mid_queued: got %0d, required 3", fifo_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_abort: got tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1", tx, busy, fifo_count, wr_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_idle: got %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_div_change();
        set_div(3);
        put(8'h5A);
        put(8'hC3);
        stop_wr();
        wait_bit(10, 100, "div_change");
        set_div(7);
        wait_frames(2, 300, "div_change");
        checks++;
        if (last_gap !== 0 || fdiv !== 7) begin
            errors++;
            $display("FAIL div_change_second: got gap=%0d div=%0d, required 0 7", last_gap, fdiv);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div_change_end: got tx=%b busy=%b, required 1 0", tx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_div0();
        test_reset_mid();
        test_div_change();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
